// File: rtl/sdr_arb_if.sv
// Handshake bundle between the SDRAM arbiter and its client/engine side.
// master: clients and engines (drive requests and completions).
// slave:  the arbiter (drives grants and status).
interface sdr_arb_if;
  logic       init_done;
  logic       wr_req_in;
  logic       rd_req_in;
  logic       wr_exit;
  logic       rd_done;
  logic       ref_done;
  logic       wr_grant;
  logic       rd_grant;
  logic       ref_req;
  logic       need_ref;
  logic       busy;
  logic [2:0] ref_pend;
  logic       ref_ovf;
  logic [2:0] arb_state;

  modport master (
    output init_done, wr_req_in, rd_req_in, wr_exit, rd_done, ref_done,
    input  wr_grant, rd_grant, ref_req, need_ref, busy, ref_pend, ref_ovf,
           arb_state
  );

  modport slave (
    input  init_done, wr_req_in, rd_req_in, wr_exit, rd_done, ref_done,
    output wr_grant, rd_grant, ref_req, need_ref, busy, ref_pend, ref_ovf,
           arb_state
  );
endinterface

// File: rtl/sdr_arb.sv
// SDRAM request arbiter and refresh scheduler.
// Holds traffic until init completes, counts refresh ticks into a small
// pending count, and hands the single command path to write, read or
// refresh using one-cycle grant pulses.
// Optional: define SDR_ARB_RR_EN to alternate write/read on conflicts
// (default build: write always wins).
//
// state   | meaning
// S_INIT  | waiting for init_done, refresh timer held
// S_IDLE  | arbitrating; at least one cycle between grants
// S_WRITE | write engine owns the command path
// S_READ  | read engine owns the command path
// S_REF   | refresh engine owns the command path
module sdr_arb #(
  parameter int unsigned REF_INTERVAL = 1300,
  parameter int unsigned REF_MAX_PEND = 4,
  parameter int unsigned CNT_W        = 11
) (
  input logic      clk,
  input logic      rst,
  sdr_arb_if.slave bus
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_WRITE = 3'd2,
    S_READ  = 3'd3,
    S_REF   = 3'd4
  } state_t;

  // Timer counts down from REF_INTERVAL-1; reaching zero is the tick.
  localparam logic [CNT_W-1:0] TMR_LOAD = CNT_W'(REF_INTERVAL - 1);
  localparam logic [2:0]       PEND_MAX = 3'(REF_MAX_PEND);

  state_t           state;
  logic [CNT_W-1:0] tmr;
  logic [2:0]       pend;
  logic             ovf_q;
  logic             wr_grant_q;
  logic             rd_grant_q;
  logic             ref_req_q;
  logic             tick;
  logic             ref_dec;
  logic             wr_win;

  assign tick    = (state != S_INIT) && (tmr == '0);
  assign ref_dec = (state == S_REF) && bus.ref_done;

`ifdef SDR_ARB_RR_EN
  logic last_wr;
  // On a write/read conflict, hand the path to whoever did not go last.
  assign wr_win = bus.wr_req_in && !(bus.rd_req_in && last_wr);
`else
  assign wr_win = bus.wr_req_in;
`endif

  // Refresh interval timer: parked at its load value until init completes.
  always_ff @(posedge clk) begin
    if (rst || state == S_INIT) begin
      tmr <= TMR_LOAD;
    end else if (tmr == '0) begin
      tmr <= TMR_LOAD;
    end else begin
      tmr <= tmr - 1'b1;
    end
  end

  // Pending-refresh count and sticky overflow; a tick and a completed
  // refresh in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (tick && pend == PEND_MAX) begin
        ovf_q <= 1'b1;
      end
      if (tick && !ref_dec && pend != PEND_MAX) begin
        pend <= pend + 3'd1;
      end else if (ref_dec && !tick && pend != '0) begin
        pend <= pend - 3'd1;
      end
    end
  end

  // Arbitration FSM; grant pulses are registered alongside the state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_INIT;
      wr_grant_q <= 1'b0;
      rd_grant_q <= 1'b0;
      ref_req_q  <= 1'b0;
`ifdef SDR_ARB_RR_EN
      last_wr    <= 1'b0;
`endif
    end else begin
      wr_grant_q <= 1'b0;
      rd_grant_q <= 1'b0;
      ref_req_q  <= 1'b0;
      case (state)
        S_INIT: begin
          if (bus.init_done) state <= S_IDLE;
        end
        S_IDLE: begin
          if (pend == PEND_MAX) begin
            state     <= S_REF;
            ref_req_q <= 1'b1;
          end else if (wr_win) begin
            state      <= S_WRITE;
            wr_grant_q <= 1'b1;
`ifdef SDR_ARB_RR_EN
            last_wr    <= 1'b1;
`endif
          end else if (bus.rd_req_in) begin
            state      <= S_READ;
            rd_grant_q <= 1'b1;
`ifdef SDR_ARB_RR_EN
            last_wr    <= 1'b0;
`endif
          end else if (pend != '0) begin
            state     <= S_REF;
            ref_req_q <= 1'b1;
          end
        end
        S_WRITE: begin
          if (bus.wr_exit) state <= S_IDLE;
        end
        S_READ: begin
          if (bus.rd_done) state <= S_IDLE;
        end
        S_REF: begin
          if (bus.ref_done) state <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase
    end
  end

  assign bus.wr_grant  = wr_grant_q;
  assign bus.rd_grant  = rd_grant_q;
  assign bus.ref_req   = ref_req_q;
  assign bus.need_ref  = (state == S_WRITE) && (pend != '0);
  assign bus.busy      = (state != S_IDLE);
  assign bus.ref_pend  = pend;
  assign bus.ref_ovf   = ovf_q;
  assign bus.arb_state = state;

endmodule

// File: tb/tb_sdr_arb.sv
// Directed bench for sdr_arb with a 16-cycle refresh interval.
// Cycle cN means N active edges after the first S_IDLE cycle (c0).
module tb_sdr_arb;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  sdr_arb_if bif ();

  sdr_arb #(
    .REF_INTERVAL(16),
    .REF_MAX_PEND(4),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bif.init_done = 1'b0;
    bif.wr_req_in = 1'b0;
    bif.rd_req_in = 1'b0;
    bif.wr_exit   = 1'b0;
    bif.rd_done   = 1'b0;
    bif.ref_done  = 1'b0;
  endtask

  // Leaves the bench in c0, the first S_IDLE cycle.
  task automatic init_seq();
    clear_inputs();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    bif.init_done = 1'b1;
    step();
  endtask

  task automatic test_reset();
    int n;
    clear_inputs();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bif.arb_state !== 3'd0 || bif.busy !== 1'b1) begin
        failures++;
        $display("FAIL reset_state: arb_state=%0d busy=%b expected 0/1", bif.arb_state, bif.busy);
      end
      checks++;
      if ({bif.wr_grant, bif.rd_grant, bif.ref_req, bif.need_ref, bif.ref_ovf} !== 5'b0 || bif.ref_pend !== 3'd0) begin
        failures++;
        $display("FAIL reset_outputs: grants/flags=%b pend=%0d expected 0", {bif.wr_grant, bif.rd_grant, bif.ref_req, bif.need_ref, bif.ref_ovf}, bif.ref_pend);
      end
    end
    rst = 1'b0;
    for (int c = 3; c <= 10; c++) begin
      step();
      checks++;
      if (bif.arb_state !== 3'd0 || bif.ref_req !== 1'b0 || bif.ref_pend !== 3'd0) begin
        failures++;
        $display("FAIL init_hold c%0d: arb_state=%0d ref_req=%b pend=%0d expected 0/0/0", c, bif.arb_state, bif.ref_req, bif.ref_pend);
      end
      if (c == 10) bif.init_done = 1'b1;
    end
    step();
    checks++;
    if (bif.arb_state !== 3'd1 || bif.busy !== 1'b0) begin
      failures++;
      $display("FAIL init_exit: arb_state=%0d busy=%b expected 1/0", bif.arb_state, bif.busy);
    end
    n = 0;
    while (bif.ref_req !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n !== 17) begin
      failures++;
      $display("FAIL first_ref_latency: got %0d cycles expected 17", n);
    end
  endtask

  task automatic test_write();
    int busy_cnt;
    int extra_wr;
    init_seq();
    bif.wr_req_in = 1'b1;
    step();
    checks++;
    if (bif.wr_grant !== 1'b1 || bif.arb_state !== 3'd2 || bif.busy !== 1'b1) begin
      failures++;
      $display("FAIL wr_grant_c1: grant=%b state=%0d busy=%b expected 1/2/1", bif.wr_grant, bif.arb_state, bif.busy);
    end
    bif.wr_req_in = 1'b0;
    busy_cnt = 1;
    extra_wr = 0;
    for (int c = 2; c <= 21; c++) begin
      step();
      if (bif.busy === 1'b1) busy_cnt++;
      if (bif.wr_grant === 1'b1) extra_wr++;
      if (c == 15) begin
        checks++;
        if (bif.need_ref !== 1'b0) begin
          failures++;
          $display("FAIL need_ref_c15: got %b expected 0", bif.need_ref);
        end
      end
      if (c == 16) begin
        checks++;
        if (bif.need_ref !== 1'b1 || bif.ref_pend !== 3'd1) begin
          failures++;
          $display("FAIL need_ref_c16: need_ref=%b pend=%0d expected 1/1", bif.need_ref, bif.ref_pend);
        end
      end
    end
    bif.wr_exit = 1'b1;
    step();
    bif.wr_exit = 1'b0;
    checks++;
    if (bif.arb_state !== 3'd1 || bif.busy !== 1'b0) begin
      failures++;
      $display("FAIL wr_return_idle: state=%0d busy=%b expected 1/0", bif.arb_state, bif.busy);
    end
    checks++;
    if (busy_cnt !== 21) begin
      failures++;
      $display("FAIL wr_busy_len: got %0d expected 21", busy_cnt);
    end
    step();
    checks++;
    if (bif.ref_req !== 1'b1 || bif.arb_state !== 3'd4) begin
      failures++;
      $display("FAIL opp_ref_c23: ref_req=%b state=%0d expected 1/4", bif.ref_req, bif.arb_state);
    end
    for (int c = 24; c <= 30; c++) begin
      step();
      if (bif.wr_grant === 1'b1) extra_wr++;
    end
    checks++;
    if (extra_wr !== 0) begin
      failures++;
      $display("FAIL wr_no_regrant: got %0d extra grants expected 0", extra_wr);
    end
  endtask

  task automatic test_read();
    init_seq();
    bif.rd_req_in = 1'b1;
    step();
    checks++;
    if (bif.rd_grant !== 1'b1 || bif.wr_grant !== 1'b0 || bif.arb_state !== 3'd3) begin
      failures++;
      $display("FAIL rd_grant_c1: rd=%b wr=%b state=%0d expected 1/0/3", bif.rd_grant, bif.wr_grant, bif.arb_state);
    end
    bif.rd_req_in = 1'b0;
    step();
    bif.wr_exit = 1'b1;
    step();
    bif.wr_exit  = 1'b0;
    bif.ref_done = 1'b1;
    step();
    bif.ref_done = 1'b0;
    checks++;
    if (bif.arb_state !== 3'd3 || bif.rd_grant !== 1'b0) begin
      failures++;
      $display("FAIL rd_ignore_foreign_done: state=%0d rd_grant=%b expected 3/0", bif.arb_state, bif.rd_grant);
    end
    bif.rd_done = 1'b1;
    step();
    bif.rd_done = 1'b0;
    checks++;
    if (bif.arb_state !== 3'd1) begin
      failures++;
      $display("FAIL rd_return_idle: state=%0d expected 1", bif.arb_state);
    end
    step();
    checks++;
    if (bif.arb_state !== 3'd1 || {bif.wr_grant, bif.rd_grant, bif.ref_req} !== 3'b000) begin
      failures++;
      $display("FAIL rd_idle_quiet: state=%0d grants=%b expected 1/000", bif.arb_state, {bif.wr_grant, bif.rd_grant, bif.ref_req});
    end
  endtask

  task automatic test_refresh();
    int n;
    init_seq();
    n = 0;
    while (bif.ref_req !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n !== 17 || bif.ref_pend !== 3'd1 || bif.arb_state !== 3'd4) begin
      failures++;
      $display("FAIL ref_first: cycle=%0d pend=%0d state=%0d expected 17/1/4", n, bif.ref_pend, bif.arb_state);
    end
    repeat (5) step();
    bif.ref_done = 1'b1;
    step();
    bif.ref_done = 1'b0;
    checks++;
    if (bif.ref_pend !== 3'd0 || bif.arb_state !== 3'd1) begin
      failures++;
      $display("FAIL ref_done_dec: pend=%0d state=%0d expected 0/1", bif.ref_pend, bif.arb_state);
    end
    n = 6;
    while (bif.ref_req !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n !== 16 || bif.ref_pend !== 3'd1) begin
      failures++;
      $display("FAIL ref_period: got %0d cycles pend=%0d expected 16/1", n, bif.ref_pend);
    end
    step();
    checks++;
    if (bif.ref_req !== 1'b0 || bif.arb_state !== 3'd4) begin
      failures++;
      $display("FAIL ref_pulse_width: ref_req=%b state=%0d expected 0/4", bif.ref_req, bif.arb_state);
    end
  endtask

  task automatic test_saturate();
    int wr_cnt;
    init_seq();
    bif.wr_req_in = 1'b1;
    wr_cnt = 0;
    for (int c = 1; c <= 85; c++) begin
      step();
      if (bif.wr_grant === 1'b1) wr_cnt++;
      if (c == 64) begin
        checks++;
        if (bif.ref_pend !== 3'd4 || bif.ref_ovf !== 1'b0) begin
          failures++;
          $display("FAIL sat_c64: pend=%0d ovf=%b expected 4/0", bif.ref_pend, bif.ref_ovf);
        end
      end
      if (c == 79) begin
        checks++;
        if (bif.ref_ovf !== 1'b0) begin
          failures++;
          $display("FAIL ovf_c79: got %b expected 0", bif.ref_ovf);
        end
      end
      if (c == 80) begin
        checks++;
        if (bif.ref_ovf !== 1'b1 || bif.ref_pend !== 3'd4 || bif.need_ref !== 1'b1) begin
          failures++;
          $display("FAIL ovf_c80: ovf=%b pend=%0d need_ref=%b expected 1/4/1", bif.ref_ovf, bif.ref_pend, bif.need_ref);
        end
      end
    end
    checks++;
    if (wr_cnt !== 1 || bif.arb_state !== 3'd2) begin
      failures++;
      $display("FAIL long_write: grants=%0d state=%0d expected 1/2", wr_cnt, bif.arb_state);
    end
    bif.wr_exit = 1'b1;
    step();
    bif.wr_exit = 1'b0;
    step();
    checks++;
    if (bif.ref_req !== 1'b1 || bif.wr_grant !== 1'b0 || bif.arb_state !== 3'd4) begin
      failures++;
      $display("FAIL urgent_ref: ref_req=%b wr_grant=%b state=%0d expected 1/0/4", bif.ref_req, bif.wr_grant, bif.arb_state);
    end
    rst = 1'b1;
    step();
    checks++;
    if (bif.arb_state !== 3'd0 || bif.ref_ovf !== 1'b0 || bif.ref_pend !== 3'd0 || {bif.wr_grant, bif.rd_grant, bif.ref_req} !== 3'b000) begin
      failures++;
      $display("FAIL mid_reset: state=%0d ovf=%b pend=%0d grants=%b expected 0/0/0/000", bif.arb_state, bif.ref_ovf, bif.ref_pend, {bif.wr_grant, bif.rd_grant, bif.ref_req});
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_tick_and_done();
    init_seq();
    bif.wr_req_in = 1'b1;
    step();
    bif.wr_req_in = 1'b0;
    for (int c = 2; c <= 32; c++) step();
    checks++;
    if (bif.ref_pend !== 3'd2) begin
      failures++;
      $display("FAIL pend_c32: got %0d expected 2", bif.ref_pend);
    end
    bif.wr_exit = 1'b1;
    step();
    bif.wr_exit = 1'b0;
    step();
    checks++;
    if (bif.ref_req !== 1'b1 || bif.arb_state !== 3'd4) begin
      failures++;
      $display("FAIL ref_c34: ref_req=%b state=%0d expected 1/4", bif.ref_req, bif.arb_state);
    end
    for (int c = 35; c <= 47; c++) step();
    bif.ref_done = 1'b1;
    step();
    bif.ref_done = 1'b0;
    checks++;
    if (bif.ref_pend !== 3'd2 || bif.arb_state !== 3'd1 || bif.ref_ovf !== 1'b0) begin
      failures++;
      $display("FAIL tick_and_done: pend=%0d state=%0d ovf=%b expected 2/1/0", bif.ref_pend, bif.arb_state, bif.ref_ovf);
    end
    step();
    checks++;
    if (bif.ref_req !== 1'b1) begin
      failures++;
      $display("FAIL ref_c49: got %b expected 1", bif.ref_req);
    end
  endtask

  task automatic test_conflict();
    int   t;
    int   n;
    logic exp_wr;
    logic was_wr;
    init_seq();
    bif.wr_req_in = 1'b1;
    bif.rd_req_in = 1'b1;
    t = 0;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (!(bif.wr_grant === 1'b1 || bif.rd_grant === 1'b1 || bif.ref_req === 1'b1) && n < 20) begin
        step();
        t++;
        n++;
      end
`ifdef SDR_ARB_RR_EN
      exp_wr = ((g % 2) == 0);
`else
      exp_wr = 1'b1;
`endif
      checks++;
      if (bif.wr_grant !== exp_wr || bif.rd_grant !== ~exp_wr) begin
        failures++;
        $display("FAIL conflict_grant%0d: wr=%b rd=%b expected %b/%b", g, bif.wr_grant, bif.rd_grant, exp_wr, ~exp_wr);
      end
      checks++;
      if (t !== 1 + 5 * g) begin
        failures++;
        $display("FAIL conflict_timing%0d: cycle %0d expected %0d", g, t, 1 + 5 * g);
      end
      was_wr = bif.wr_grant;
      repeat (3) step();
      t += 3;
      if (was_wr) bif.wr_exit = 1'b1;
      else        bif.rd_done = 1'b1;
      step();
      t++;
      bif.wr_exit = 1'b0;
      bif.rd_done = 1'b0;
    end
    clear_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    clear_inputs();
    test_reset();
    test_write();
    test_read();
    test_refresh();
    test_saturate();
    test_tick_and_done();
    test_conflict();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
